// File: rtl/dm_responder.sv
// dm_responder: data-side memory responder for the MIPS core M stage.
// Combinational loads, byte-enabled stores, and a show-ahead trace FIFO of committed stores.
`default_nettype none

module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [31:0]                        m_data_addr,
    input  logic [31:0]                        m_data_wdata,
    input  logic [3:0]                         m_data_byteen,
    input  logic [31:0]                        m_inst_addr,
    output logic [31:0]                        m_data_rdata,
    output logic                               trace_valid,
    input  logic                               trace_ready,
    output logic [31:0]                        trace_pc,
    output logic [31:0]                        trace_addr,
    output logic [31:0]                        trace_data,
    output logic [$clog2(TRACE_DEPTH+1)-1:0]   trace_count,
    output logic                               trace_overflow,
    output logic                               addr_err
);

    localparam int MEM_WORDS = 1 << ADDR_WIDTH;
    localparam int PTR_W     = $clog2(TRACE_DEPTH);
    localparam int CNT_W     = $clog2(TRACE_DEPTH + 1);

    logic [31:0]           mem [0:MEM_WORDS-1];
    logic [31:0]           fifo_pc   [0:TRACE_DEPTH-1];
    logic [31:0]           fifo_addr [0:TRACE_DEPTH-1];
    logic [31:0]           fifo_data [0:TRACE_DEPTH-1];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           old_word;
    logic [31:0]           merged;
    logic                  store_ok;
    logic                  store_bad;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  unused_addr_bits;

    // The core always drives a word-aligned address; the low bits carry no information.
    assign unused_addr_bits = ^m_data_addr[1:0];

    assign in_range     = (m_data_addr[31:ADDR_WIDTH+2] == '0);
    assign word_idx     = m_data_addr[ADDR_WIDTH+1:2];
    assign old_word     = mem[word_idx];
    assign m_data_rdata = in_range ? old_word : 32'h0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    assign store_ok  = (m_data_byteen != 4'b0000) && in_range;
    assign store_bad = (m_data_byteen != 4'b0000) && !in_range;

    assign trace_valid = (trace_count != '0);
    assign fifo_full   = (trace_count == CNT_W'(TRACE_DEPTH));
    assign pop         = trace_valid && trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = store_ok && (!fifo_full || pop);
    assign drop        = store_ok && fifo_full && !pop;

    assign trace_pc   = fifo_pc[rd_ptr];
    assign trace_addr = fifo_addr[rd_ptr];
    assign trace_data = fifo_data[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_ok) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                fifo_pc[i]   <= 32'h0;
                fifo_addr[i] <= 32'h0;
                fifo_data[i] <= 32'h0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= m_inst_addr;
            fifo_addr[wr_ptr] <= {m_data_addr[31:2], 2'b00};
            fifo_data[wr_ptr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            trace_count    <= '0;
            trace_overflow <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                trace_count <= trace_count + CNT_W'(1);
            end else if (pop && !push) begin
                trace_count <= trace_count - CNT_W'(1);
            end
            if (drop) begin
                trace_overflow <= 1'b1;
            end
            if (store_bad) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed bench with a trace scoreboard and a reference memory model.
`default_nettype none

module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_count;
    logic        trace_overflow;
    logic        addr_err;

    dm_responder #(.ADDR_WIDTH(12), .TRACE_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .m_data_rdata   (m_data_rdata),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow),
        .addr_err       (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] mdl [int];
    logic        exp_ovf;
    logic        exp_err;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return a[31:14] == 18'h0;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        int k;
        k = int'(a[13:2]);
        if (!in_rng(a)) return 32'h0;
        if (mdl.exists(k)) return mdl[k];
        return 32'h0;
    endfunction

    // One clock with the currently driven inputs: pre-edge output checks, model update, post-edge checks.
    task automatic tick();
        logic [31:0] old_w, mrg;
        logic        do_pop;
        entry_t      e;
        #1;
        chk("rdata", m_data_rdata, mread(m_data_addr));
        do_pop = (sb.size() != 0) && trace_ready;
        if (do_pop) begin
            e = sb.pop_front();
            chk("head_pc", trace_pc, e.pc);
            chk("head_addr", trace_addr, e.addr);
            chk("head_data", trace_data, e.data);
        end
        if (m_data_byteen != 4'b0000) begin
            if (in_rng(m_data_addr)) begin
                old_w = mread(m_data_addr);
                for (int i = 0; i < 4; i++)
                    mrg[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : old_w[8*i +: 8];
                mdl[int'(m_data_addr[13:2])] = mrg;
                if (sb.size() < 8) begin
                    e.pc   = m_inst_addr;
                    e.addr = {m_data_addr[31:2], 2'b00};
                    e.data = mrg;
                    sb.push_back(e);
                end else begin
                    exp_ovf = 1'b1;
                end
            end else begin
                exp_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("count", 32'(trace_count), 32'(sb.size()));
        chk("valid", 32'(trace_valid), 32'(sb.size() != 0));
        chk("overflow", 32'(trace_overflow), 32'(exp_ovf));
        chk("addr_err", 32'(addr_err), 32'(exp_err));
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] pc);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        m_inst_addr   = pc;
        tick();
        m_data_byteen = 4'b0000;
    endtask

    task automatic drain();
        trace_ready   = 1'b1;
        m_data_byteen = 4'b0000;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("drained", 32'(trace_valid), 32'h0);
        trace_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_ovf       = 1'b0;
        exp_err       = 1'b0;
        reset         = 1'b1;
        trace_ready   = 1'b0;
        m_data_addr   = 32'h0;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'b0000;
        m_inst_addr   = 32'h0;
        #1 reset = 1'b0;
        #2;
        chk("rst_rdata", m_data_rdata, 32'h0);
        chk("rst_valid", 32'(trace_valid), 32'h0);
        chk("rst_count", 32'(trace_count), 32'h0);
        chk("rst_flags", {30'h0, trace_overflow, addr_err}, 32'h0);
        chk("rst_head", trace_pc | trace_addr | trace_data, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Word store and its trace entry
        store(32'h4, 32'h12345678, 4'b1111, 32'h3000);
        m_data_addr = 32'h4;
        #1;
        chk("ws_rdata", m_data_rdata, 32'h12345678);
        chk("ws_pc", trace_pc, 32'h3000);
        chk("ws_addr", trace_addr, 32'h4);
        chk("ws_data", trace_data, 32'h12345678);
        chk("ws_count", 32'(trace_count), 32'h1);

        // Byte merge, including read-during-write returning old data
        store(32'h4, 32'h0000BEEF, 4'b0011, 32'h3004);
        chk("bm_sb_data", sb[1].data, 32'h1234BEEF);
        store(32'h4, 32'hAA000000, 4'b1000, 32'h3008);
        m_data_addr = 32'h4;
        #1;
        chk("bm_rdata", m_data_rdata, 32'hAA34BEEF);
        drain();

        // Fill to full, then push with a simultaneous pop
        for (int i = 0; i < 8; i++)
            store(32'h100 + 32'(4*i), 32'hA0000000 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i));
        chk("full_count", 32'(trace_count), 32'h8);
        chk("full_ovf", 32'(trace_overflow), 32'h0);
        trace_ready = 1'b1;
        store(32'h200, 32'h5A5A5A5A, 4'b1111, 32'h4100);
        chk("pp_count", 32'(trace_count), 32'h8);
        chk("pp_ovf", 32'(trace_overflow), 32'h0);
        drain();

        // Overflow: nine stores into an 8-deep FIFO with no consumer
        for (int i = 0; i < 9; i++)
            store(32'h300 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'b1111, 32'h5000 + 32'(4*i));
        chk("ov_count", 32'(trace_count), 32'h8);
        chk("ov_flag", 32'(trace_overflow), 32'h1);
        drain();

        // Out-of-range store must not alias onto word 0
        store(32'h0, 32'hCAFEF00D, 4'b1111, 32'h6000);
        drain();
        store(32'h00004000, 32'hDEADBEEF, 4'b1111, 32'h6004);
        chk("oor_err", 32'(addr_err), 32'h1);
        chk("oor_valid", 32'(trace_valid), 32'h0);
        m_data_addr = 32'h00004000;
        #1;
        chk("oor_rdata", m_data_rdata, 32'h0);
        m_data_addr = 32'h0;
        #1;
        chk("oor_word0", m_data_rdata, 32'hCAFEF00D);

        // Asynchronous reset in the middle of a drain
        store(32'h10, 32'h11111111, 4'b1111, 32'h7000);
        store(32'h14, 32'h22222222, 4'b1111, 32'h7004);
        store(32'h18, 32'h33333333, 4'b1111, 32'h7008);
        chk("ar_count3", 32'(trace_count), 32'h3);
        trace_ready = 1'b1;
        m_data_addr = 32'h14;
        #1 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(trace_valid), 32'h0);
        chk("ar_count", 32'(trace_count), 32'h0);
        chk("ar_rdata", m_data_rdata, 32'h0);
        chk("ar_flags", {30'h0, trace_overflow, addr_err}, 32'h0);
        chk("ar_head", trace_pc | trace_addr | trace_data, 32'h0);
        sb.delete();
        mdl.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        trace_ready = 1'b0;
        reset = 1'b1;
        store(32'h20, 32'h0BADF00D, 4'b0101, 32'h8000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/dm_responder.md
# dm_responder

Data-side memory responder for the pipelined MIPS core's external data port. It serves the core's same-cycle load reads and byte-enabled stores on `m_data_*`. Every committed store is recorded into a trace FIFO, drained by a ready/valid consumer such as a bench logger or checker. It sits outside `mips`, opposite the core's M stage.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `TRACE_DEPTH`, 8, trace FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 resets all state immediately.
- `m_data_addr`  in  32  byte address from core; core drives bits [1:0] as 0.
- `m_data_wdata`  in  32  store data; core supplies it already lane-aligned.
- `m_data_byteen`  in  4  byte-lane write enables; bit i writes bits [8i+7:8i]; 0000 means no store.
- `m_inst_addr`  in  32  PC of the instruction in M; captured into the trace.
- `m_data_rdata`  out  32  read word at `m_data_addr`, combinational.
- `trace_valid`  out  1  FIFO non-empty.
- `trace_ready`  in  1  consumer accepts head entry.
- `trace_pc`  out  32  head entry: store PC.
- `trace_addr`  out  32  head entry: word-aligned byte address.
- `trace_data`  out  32  head entry: full merged word after the store.
- `trace_count`  out  clog2(TRACE_DEPTH+1)  occupied entries.
- `trace_overflow`  out  1  sticky; a store trace was dropped.
- `addr_err`  out  1  sticky; a nonzero-byteen access hit an out-of-range address.

## Operation
- In range means `m_data_addr[31:ADDR_WIDTH+2]` == 0. Word index is `m_data_addr[ADDR_WIDTH+1:2]`.
- Read path:
  - `m_data_rdata` = mem[index] when in range, else 0.
  - Purely combinational; it reflects pre-edge contents.
  - No read enable; a read is always presented.
- Store, when `byteen` != 0 and in range, at the rising edge:
  - merged = per lane, `byteen[i]` ? `wdata` byte i : old byte i.
  - mem[index] <= merged.
  - Push {`m_inst_addr`, {addr[31:2],2'b00}, merged} into the trace.
- Store out of range:
  - Memory is unchanged and no trace entry is pushed.
  - `addr_err` <= 1.
- Trace FIFO:
  - Circular buffer with read and write pointers, each mod `TRACE_DEPTH`, plus a count.
  - Outputs are show-ahead: `trace_*` always present the head entry.
  - Pop occurs when `trace_valid` && `trace_ready`.
  - Push when not full: accepted.
  - Push when full with a pop in the same cycle: accepted, count unchanged.
  - Push when full without a pop: entry dropped, `trace_overflow` <= 1.
  - Pop when empty: impossible, since `trace_valid` = 0. `trace_ready` is ignored.
  - Push and pop together when non-full: count unchanged and both pointers advance.
- Sticky flags clear only on reset.

## Timing
- Reset asserted (`reset`=0), asynchronously:
  - All memory words become 0.
  - Pointers and count become 0, so `trace_valid`=0 and `trace_count`=0.
  - `trace_overflow`=0 and `addr_err`=0.
  - `m_data_rdata`=0; `trace_pc`/`trace_addr`/`trace_data` = 0.
- Reset mid-operation: a store presented in the same cycle is lost; FIFO contents are discarded.
- Reset release: normal operation from the first rising edge with `reset`=1.
- Load latency is 0 cycles, combinational, as the core's M stage expects.
- A store at edge N is visible on `m_data_rdata` after edge N, so a load in cycle N+1 sees it.
- Read-during-write to the same word in cycle N returns old data.
- Trace latency: a store at edge N raises `trace_valid` after edge N when the FIFO was empty. The head is visible in cycle N+1.
- Pop at edge N advances the head after edge N.
- Pointer wrap from `TRACE_DEPTH`-1 to 0 needs no bubble.

## Test plan
- Reset and word store:
  - After reset, read addr 0x0 gives rdata=0 and `trace_valid`=0.
  - Store 0x12345678 to 0x4 with byteen=1111 and pc=0x3000.
  - Next cycle, read 0x4 gives 0x12345678. The trace head is {0x3000, 0x4, 0x12345678} and count=1.
- Byte merge: over 0x12345678 at 0x4, apply two stores, then read 0x4 and expect 0xAA34BEEF.
  - Store byteen=0011 with wdata 0x0000BEEF; trace_data=0x1234BEEF.
  - Then store byteen=1000 with wdata 0xAA000000.
- FIFO full and overflow:
  - With `trace_ready`=0, perform 9 stores with TRACE_DEPTH=8.
  - Expect count=8 and `trace_overflow`=1.
  - Draining yields the first 8 entries in order.
- Full push+pop: with the FIFO full and `trace_ready`=1, a store in the same cycle keeps count=8 and `trace_overflow`=0. The new entry appears after the 7 older ones.
- Out of range: with ADDR_WIDTH=12, store to 0x00004000.
  - Expect `addr_err`=1, no trace push, and read 0x00004000 = 0.
  - Word 0x0 is unchanged.
- Async reset mid-drain: drop `reset` between edges while count=3. Expect `trace_valid`=0 and count=0 immediately, and memory reads 0 with no clock edge.
